// File: rtl/uart_frame_pkg.sv
// Shared constants and types for the UART frame receiver: SOF marker, one-hot frame
// type codes (same encoding as the sender's transmit_sel), error codes and FSM states.
package uart_frame_pkg;

    localparam logic [7:0] SOF_BYTE   = 8'hA5;
    localparam logic [4:0] TYPE_KEY   = 5'b00001;
    localparam logic [4:0] TYPE_PT    = 5'b00010;
    localparam logic [4:0] TYPE_CT    = 5'b00100;
    localparam logic [4:0] TYPE_TRACE = 5'b01000;
    localparam logic [4:0] TYPE_PARAM = 5'b10000;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_TYPE    = 3'd1,
        ERR_LEN     = 3'd2,
        ERR_CHK     = 3'd3,
        ERR_UART    = 3'd4,
        ERR_TIMEOUT = 3'd5
    } err_code_e;

    typedef enum logic [2:0] {
        S_IDLE, S_TYPE, S_LEN_HI, S_LEN_LO, S_PAYLOAD, S_CHECK
    } frame_state_e;

    typedef enum logic [1:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP
    } rx_state_e;

    function automatic logic is_frame_type(input logic [7:0] b);
        return (b[7:5] == 3'b000) &&
               (b[4:0] == TYPE_KEY || b[4:0] == TYPE_PT || b[4:0] == TYPE_CT ||
                b[4:0] == TYPE_TRACE || b[4:0] == TYPE_PARAM);
    endfunction

endpackage

// File: rtl/uart_frame_receiver_if.sv
// Payload write port and frame status bundle of the UART frame receiver.
// master = receiver side (drives), slave = consumer side (observes).
interface uart_frame_receiver_if #(
    parameter int ADDR_W = 16
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [4:0]        frame_type;
    logic [ADDR_W-1:0] frame_len;
    logic              frame_done;
    logic              frame_err;
    logic [2:0]        err_code;
    logic              busy;

    modport master (
        output wr_en, wr_addr, wr_data, frame_type, frame_len,
               frame_done, frame_err, err_code, busy
    );
    modport slave (
        input  wr_en, wr_addr, wr_data, frame_type, frame_len,
               frame_done, frame_err, err_code, busy
    );
endinterface

// File: rtl/uart_rx_byte.sv
// UART 8N1 byte deserialiser: 2-flop synchroniser, mid-bit sampling, start-glitch
// rejection; pulses vld_o (good stop bit) or err_o (stop bit low) per byte.
module uart_rx_byte
    import uart_frame_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       vld_o,
    output logic       err_o
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          vld_q, vld_d, err_q, err_d;
    logic          rx_s1_q, rx_s2_q, rx_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            vld_q     <= 1'b0;
            err_q     <= 1'b0;
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            vld_q     <= vld_d;
            err_q     <= err_d;
            rx_s1_q   <= rx_i;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        vld_d   = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (rx_prev_q && !rx_s2_q) state_d = RX_START;
            end
            // Start bit must still be low half a bit later, else it was a glitch
            RX_START: if (cnt_q == HALF) begin
                cnt_d   = '0;
                bit_d   = '0;
                state_d = rx_s2_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (cnt_q == FULL) begin
                cnt_d   = '0;
                shift_d = {rx_s2_q, shift_q[7:1]};
                bit_d   = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = RX_STOP;
            end
            RX_STOP: if (cnt_q == FULL) begin
                state_d = RX_IDLE;
                vld_d   = rx_s2_q;
                err_d   = !rx_s2_q;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign data_o = shift_q;
    assign vld_o  = vld_q;
    assign err_o  = err_q;
endmodule

// File: rtl/uart_frame_receiver.sv
// Frame layer: SOF/TYPE/LEN/payload/CHK parsing over uart_rx_byte, payload write port
// and status. Define UART_FRAME_RX_TIMEOUT_EN to build the inter-byte timeout.
module uart_frame_receiver
    import uart_frame_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int MAX_LEN      = 1024,
    parameter int ADDR_W       = 16,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx,
    input  logic                   enable,
    uart_frame_receiver_if.master  bus
);
    logic [7:0]  rx_byte;
    logic        byte_vld, byte_err;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
        .clk(clk), .rst(rst), .rx_i(rx),
        .data_o(rx_byte), .vld_o(byte_vld), .err_o(byte_err)
    );

    frame_state_e      state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d, addr_q, addr_d, len_q, len_d;
    logic [7:0]        len_hi_q, len_hi_d, chk_q, chk_d, data_q, data_d;
    logic [4:0]        type_q, type_d;
    logic              wr_en_q, wr_en_d, done_q, done_d, err_q, err_d;
    err_code_e         code_q, code_d;
    logic [15:0]       len_w;

`ifdef UART_FRAME_RX_TIMEOUT_EN
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_BITS * CLKS_PER_BIT - 1);
    logic [31:0] to_q;

    // Restarts on every received byte; only meaningful while a frame is open
    always_ff @(posedge clk) begin
        if (rst || state_q == S_IDLE) to_q <= '0;
        else if (byte_vld)            to_q <= 32'd1;
        else                          to_q <= to_q + 32'd1;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            len_hi_q <= '0;
            chk_q    <= '0;
            data_q   <= '0;
            type_q   <= '0;
            wr_en_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= ERR_NONE;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            len_hi_q <= len_hi_d;
            chk_q    <= chk_d;
            data_q   <= data_d;
            type_q   <= type_d;
            wr_en_q  <= wr_en_d;
            done_q   <= done_d;
            err_q    <= err_d;
            code_q   <= code_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        len_d    = len_q;
        len_hi_d = len_hi_q;
        chk_d    = chk_q;
        data_d   = data_q;
        type_d   = type_q;
        wr_en_d  = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        code_d   = code_q;
        len_w    = {len_hi_q, rx_byte};
        if (!enable) begin
            state_d = S_IDLE;
        end else if (byte_err && state_q != S_IDLE) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            code_d  = ERR_UART;
        end else if (byte_vld) begin
            chk_d = chk_q ^ rx_byte;
            unique case (state_q)
                S_IDLE: if (rx_byte == SOF_BYTE) begin
                    state_d = S_TYPE;
                    chk_d   = '0;
                end
                S_TYPE: if (is_frame_type(rx_byte)) begin
                    state_d = S_LEN_HI;
                    type_d  = rx_byte[4:0];
                end else begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                    code_d  = ERR_TYPE;
                end
                S_LEN_HI: begin
                    len_hi_d = rx_byte;
                    state_d  = S_LEN_LO;
                end
                S_LEN_LO: if (len_w == 16'd0 || {16'd0, len_w} > 32'(MAX_LEN)) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                    code_d  = ERR_LEN;
                end else begin
                    len_d   = ADDR_W'(len_w);
                    idx_d   = '0;
                    state_d = S_PAYLOAD;
                end
                S_PAYLOAD: begin
                    wr_en_d = 1'b1;
                    addr_d  = idx_q;
                    data_d  = rx_byte;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == len_q - 1'b1) state_d = S_CHECK;
                end
                S_CHECK: begin
                    state_d = S_IDLE;
                    if (rx_byte == chk_q) begin
                        done_d = 1'b1;
                    end else begin
                        err_d  = 1'b1;
                        code_d = ERR_CHK;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
`ifdef UART_FRAME_RX_TIMEOUT_EN
        if (enable && !byte_vld && !byte_err && state_q != S_IDLE && to_q == TO_LAST) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            code_d  = ERR_TIMEOUT;
        end
`endif
    end

    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = addr_q;
    assign bus.wr_data    = data_q;
    assign bus.frame_type = type_q;
    assign bus.frame_len  = len_q;
    assign bus.frame_done = done_q;
    assign bus.frame_err  = err_q;
    assign bus.err_code   = code_q;
    assign bus.busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_frame_receiver.sv
// Directed bench for uart_frame_receiver with a shortened bit time.
// The timeout scenario runs only when UART_FRAME_RX_TIMEOUT_EN is defined.
module tb_uart_frame_receiver;
    localparam int CPB      = 4;
    localparam int MAX_LEN  = 1024;
    localparam int ADDR_W   = 16;
    localparam int TO_BITS  = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx = 1'b1;
    logic enable = 1'b1;

    always #5 clk = ~clk;

    uart_frame_receiver_if #(.ADDR_W(ADDR_W)) bus ();

    uart_frame_receiver #(
        .CLKS_PER_BIT(CPB), .MAX_LEN(MAX_LEN), .ADDR_W(ADDR_W), .TIMEOUT_BITS(TO_BITS)
    ) u_dut (
        .clk(clk), .rst(rst), .rx(rx), .enable(enable), .bus(bus)
    );

    int total = 0;
    int bad = 0;

    // Observation log, sampled on the falling edge
    logic [15:0] log_addr [0:4095];
    logic [7:0]  log_data [0:4095];
    int wr_total = 0, done_total = 0, err_total = 0;
    int cyc = 0, err_cyc = 0, vld_cyc = 0;
    logic [2:0] last_err = 3'd0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bus.wr_en && wr_total < 4096) begin
            log_addr[wr_total] <= bus.wr_addr;
            log_data[wr_total] <= bus.wr_data;
            wr_total <= wr_total + 1;
        end
        if (bus.frame_done) done_total <= done_total + 1;
        if (bus.frame_err) begin
            err_total <= err_total + 1;
            last_err  <= bus.err_code;
            err_cyc   <= cyc;
        end
        if (u_dut.byte_vld) vld_cyc <= cyc;
    end

    logic [7:0] payload [0:1023];

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] typ, input int len, input bit bad_chk,
                              input int bad_stop_idx);
        logic [7:0] chk;
        logic [15:0] l16;
        l16 = 16'(len);
        chk = typ ^ l16[15:8] ^ l16[7:0];
        send_byte(8'hA5, 1'b1);
        send_byte(typ, 1'b1);
        send_byte(l16[15:8], 1'b1);
        send_byte(l16[7:0], 1'b1);
        for (int i = 0; i < len; i++) begin
            if (i == bad_stop_idx) begin
                send_byte(payload[i], 1'b0);
                return;
            end
            send_byte(payload[i], 1'b1);
            chk = chk ^ payload[i];
        end
        send_byte(bad_chk ? (chk ^ 8'h01) : chk, 1'b1);
    endtask

    task automatic check_writes(input string name, input int base, input int n);
        int first_bad;
        first_bad = -1;
        for (int i = 0; i < n; i++)
            if (first_bad < 0 && (log_addr[base+i] !== 16'(i) || log_data[base+i] !== payload[i]))
                first_bad = i;
        total++;
        if (first_bad >= 0) begin
            bad++;
            $display("FAIL %s write[%0d]: got addr=%0d data=%02h, need addr=%0d data=%02h", name,
                     first_bad, log_addr[base+first_bad], log_data[base+first_bad],
                     first_bad, payload[first_bad]);
        end
    endtask

    task automatic check_int(input string name, input int got, input int need);
        total++;
        if (got !== need) begin
            bad++;
            $display("FAIL %s: got %0d, need %0d", name, got, need);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        total++; if (bus.wr_en !== 1'b0 || bus.frame_done !== 1'b0 || bus.frame_err !== 1'b0) begin
            bad++; $display("FAIL reset_pulses: got en=%b done=%b err=%b, need 0", bus.wr_en, bus.frame_done, bus.frame_err); end
        total++; if (bus.busy !== 1'b0 || bus.err_code !== 3'd0 || bus.frame_type !== 5'd0) begin
            bad++; $display("FAIL reset_status: got busy=%b code=%0d type=%b, need 0", bus.busy, bus.err_code, bus.frame_type); end
        total++; if (bus.wr_addr !== 16'd0 || bus.wr_data !== 8'd0 || bus.frame_len !== 16'd0) begin
            bad++; $display("FAIL reset_data: got addr=%0d data=%0d len=%0d, need 0", bus.wr_addr, bus.wr_data, bus.frame_len); end
        rst = 1'b0;
        idle_bits(2);
    endtask

    task automatic test_pt_good();
        int w0, d0, e0;
        w0 = wr_total; d0 = done_total; e0 = err_total;
        for (int i = 0; i < 16; i++) payload[i] = 8'(i);
        send_frame(8'h02, 16, 1'b0, -1);
        idle_bits(3);
        check_int("pt_writes", wr_total - w0, 16);
        check_writes("pt_data", w0, 16);
        check_int("pt_done", done_total - d0, 1);
        check_int("pt_err", err_total - e0, 0);
        check_int("pt_type", int'(bus.frame_type), 2);
        check_int("pt_len", int'(bus.frame_len), 16);
        check_int("pt_busy", int'(bus.busy), 0);
    endtask

    task automatic test_bad_chk();
        int w0, d0, e0;
        w0 = wr_total; d0 = done_total; e0 = err_total;
        send_frame(8'h02, 16, 1'b1, -1);
        idle_bits(3);
        check_int("chk_writes", wr_total - w0, 16);
        check_int("chk_done", done_total - d0, 0);
        check_int("chk_err", err_total - e0, 1);
        check_int("chk_code", int'(last_err), 3);
    endtask

    task automatic test_bad_type_len();
        int w0, e0;
        w0 = wr_total; e0 = err_total;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        idle_bits(3);
        check_int("type_err", err_total - e0, 1);
        check_int("type_code", int'(last_err), 1);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h04, 1'b1);
        send_byte(8'h01, 1'b1);
        idle_bits(3);
        check_int("len_err", err_total - e0, 2);
        check_int("len_code", int'(last_err), 2);
        check_int("len_type_updated", int'(bus.frame_type), 1);
        check_int("len_kept", int'(bus.frame_len), 16);
        check_int("type_len_writes", wr_total - w0, 0);
    endtask

    task automatic test_uart_err();
        int w0, d0, e0;
        w0 = wr_total; d0 = done_total; e0 = err_total;
        payload[0] = 8'h11; payload[1] = 8'h22; payload[2] = 8'h33;
        payload[3] = 8'h44; payload[4] = 8'h55;
        send_frame(8'h10, 5, 1'b0, 2);
        idle_bits(3);
        check_int("uart_writes", wr_total - w0, 2);
        check_int("uart_err", err_total - e0, 1);
        check_int("uart_code", int'(last_err), 4);
        check_int("uart_busy", int'(bus.busy), 0);
        w0 = wr_total;
        payload[0] = 8'hAA; payload[1] = 8'hBB; payload[2] = 8'hCC;
        send_frame(8'h10, 3, 1'b0, -1);
        idle_bits(3);
        check_int("param_done", done_total - d0, 1);
        check_int("param_writes", wr_total - w0, 3);
        check_writes("param_data", w0, 3);
        check_int("param_type", int'(bus.frame_type), 16);
        check_int("param_noerr", err_total - e0, 1);
    endtask

    task automatic test_garbage_trace();
        int w0, d0, e0;
        w0 = wr_total; d0 = done_total; e0 = err_total;
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h5A, 1'b1);
        rx = 1'b0;
        @(negedge clk);
        idle_bits(3);
        check_int("garbage_busy", int'(bus.busy), 0);
        for (int i = 0; i < 1024; i++) payload[i] = 8'(i * 7 + 3);
        send_frame(8'h08, 1024, 1'b0, -1);
        idle_bits(3);
        check_int("trace_done", done_total - d0, 1);
        check_int("trace_err", err_total - e0, 0);
        check_int("trace_writes", wr_total - w0, 1024);
        check_writes("trace_data", w0, 1024);
        check_int("trace_len", int'(bus.frame_len), 1024);
        check_int("trace_type", int'(bus.frame_type), 8);
    endtask

    task automatic test_back_to_back();
        int w0, d0;
        w0 = wr_total; d0 = done_total;
        payload[0] = 8'h01; payload[1] = 8'h02;
        send_frame(8'h01, 2, 1'b0, -1);
        check_int("b2b_first_type", int'(bus.frame_type), 1);
        payload[0] = 8'h5C; payload[1] = 8'hA5; payload[2] = 8'h00;
        send_frame(8'h04, 3, 1'b0, -1);
        idle_bits(3);
        check_int("b2b_done", done_total - d0, 2);
        check_int("b2b_writes", wr_total - w0, 5);
        check_writes("b2b_data", w0 + 2, 3);
        check_int("b2b_type", int'(bus.frame_type), 4);
        check_int("b2b_len", int'(bus.frame_len), 3);
    endtask

    task automatic test_enable();
        int w0, d0, e0;
        w0 = wr_total; d0 = done_total; e0 = err_total;
        enable = 1'b0;
        for (int i = 0; i < 4; i++) payload[i] = 8'(8'hF0 + i);
        send_frame(8'h02, 4, 1'b0, -1);
        idle_bits(3);
        check_int("en_writes", wr_total - w0, 0);
        check_int("en_done", done_total - d0, 0);
        check_int("en_err", err_total - e0, 0);
        check_int("en_busy", int'(bus.busy), 0);
        enable = 1'b1;
        idle_bits(2);
    endtask

`ifdef UART_FRAME_RX_TIMEOUT_EN
    task automatic test_timeout();
        int e0, waited;
        e0 = err_total;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h08, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h04, 1'b1);
        waited = 0;
        while (err_total == e0 && waited < TO_BITS * CPB + 200) begin
            @(negedge clk);
            waited++;
        end
        check_int("to_err", err_total - e0, 1);
        check_int("to_code", int'(last_err), 5);
        check_int("to_delay", err_cyc - vld_cyc, TO_BITS * CPB);
        check_int("to_busy", int'(bus.busy), 0);
    endtask
`endif

    task automatic test_reset_mid();
        int e0;
        e0 = err_total;
        for (int i = 0; i < 8; i++) payload[i] = 8'(8'h81 + i);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h04, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h08, 1'b1);
        for (int i = 0; i < 3; i++) send_byte(payload[i], 1'b1);
        idle_bits(2);
        check_int("mid_busy_before", int'(bus.busy), 1);
        rst = 1'b1;
        @(negedge clk);
        check_int("mid_busy", int'(bus.busy), 0);
        check_int("mid_type", int'(bus.frame_type), 0);
        check_int("mid_len", int'(bus.frame_len), 0);
        check_int("mid_data", int'(bus.wr_data), 0);
        check_int("mid_code", int'(bus.err_code), 0);
        rst = 1'b0;
        idle_bits(3);
        check_int("mid_no_err", err_total - e0, 0);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_pt_good();
        test_bad_chk();
        test_bad_type_len();
        test_uart_err();
        test_garbage_trace();
        test_back_to_back();
        test_enable();
`ifdef UART_FRAME_RX_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, need finish within budget");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/uart_frame_receiver.md
Name: uart_frame_receiver

Overview:
- Receive-side counterpart of the trace-readout sender. Deserialises the UART byte stream carrying PARAM/KEY/PT/CT/TRACE frames and validates framing and checksum.
- Streams each payload byte out through a memory write port and reports frame type, length and status.
- Used for on-chip loopback verification of the sender and as the command-frame ingest path from the host.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200).
- MAX_LEN, 1024, largest legal payload length in bytes.
- ADDR_W, 16, width of the payload write address.
- TIMEOUT_BITS, 32, inter-byte timeout in bit periods (used only with the optional feature).

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  UART serial input, idle high, 8N1, LSB first.
- enable  in  1  when low, completed bytes are discarded and the frame FSM is held in IDLE.
- wr_en  out  1  one-cycle strobe per payload byte.
- wr_addr  out  ADDR_W  payload byte index, starting at 0 for each frame.
- wr_data  out  8  payload byte.
- frame_type  out  5  one-hot type of the current/last frame: 00001 KEY, 00010 PT, 00100 CT, 01000 TRACE, 10000 PARAM.
- frame_len  out  ADDR_W  declared payload length of the last accepted header.
- frame_done  out  1  one-cycle pulse: frame received with a good checksum.
- frame_err  out  1  one-cycle pulse: frame aborted.
- err_code  out  3  cause of the last error: 1 bad type, 2 bad length, 3 checksum, 4 UART framing, 5 timeout. Holds until the next error.
- busy  out  1  high from SOF accepted until done/err.

Behaviour:
- Reset: all outputs 0 and both FSMs in IDLE. Reset mid-frame discards the frame with no err pulse.
- Byte layer (sub-module):
  - 2-flop synchroniser on rx.
  - Falling edge starts reception; start bit re-sampled at CLKS_PER_BIT/2 and, if high, treated as a glitch and the layer returns to idle.
  - Data bits sampled at mid-bit.
  - Stop bit must be 1, otherwise byte_err.
  - byte_vld is a 1-cycle pulse, asserted 1 cycle after the stop-bit sample.
- Frame format: SOF 0xA5, TYPE, LEN_HI, LEN_LO, LEN payload bytes, CHK.
  - CHK = XOR of TYPE, LEN_HI, LEN_LO and all payload bytes.
- Frame FSM states: IDLE, TYPE, LEN_HI, LEN_LO, PAYLOAD, CHECK.
  - IDLE: any byte other than 0xA5 is ignored silently. On 0xA5 go to TYPE and assert busy.
  - TYPE: byte must be exactly one of the five one-hot codes, else err 1.
  - LEN_LO: length 0 or length > MAX_LEN gives err 2. Otherwise latch frame_len and go to PAYLOAD.
  - PAYLOAD: each byte is written with wr_en=1, wr_addr=index, wr_data=byte, in the cycle after byte_vld.
    - After index frame_len-1, go to CHECK.
    - wr_addr never wraps; the length check guarantees this.
  - CHECK: match gives frame_done; mismatch gives err 3. Either way return to IDLE next cycle.
- A byte_err in any non-IDLE state gives err 4 and a return to IDLE. In IDLE, byte_err is ignored.
- Errors are reported after payload bytes were already written. The consumer must treat memory contents as valid only on frame_done.
- A new SOF arriving in the same cycle as frame_done/frame_err is processed, because the FSM is in IDLE the next cycle.
- frame_type updates at TYPE acceptance.
- Throughput: a full frame of back-to-back bytes is accepted with no gaps.

Optional Feature:
- Macro: UART_FRAME_RX_TIMEOUT_EN.
- Defined: a counter restarts on every byte_vld while busy. If it reaches TIMEOUT_BITS×CLKS_PER_BIT cycles, frame_err fires with err_code 5 and the FSM returns to IDLE.
- Undefined: no counter is built, and a stalled frame holds busy indefinitely until rst.

Decomposition:
- Shared package uart_frame_pkg:
  - SOF constant 0xA5.
  - Type one-hot constants, shared with the sender's transmit_sel encoding.
  - err_code enum.
  - Frame FSM state typedef.
- One sub-module, uart_rx_byte: synchroniser, bit timing, byte_vld/byte_err.

Test Plan:
- PT frame "A5 02 00 10", payload 00..0F, CHK = 0x02^0x10^XOR(00..0F) = 0x12 -> 16 wr_en strobes at addr 0..15 with matching data, then frame_done, frame_type=00010, frame_len=16.
- Same frame with CHK 0x13 -> 16 writes, then frame_err with err_code 3 and no frame_done.
- TYPE 0x03, or LEN 0x0401 -> frame_err with err_code 1, or with err_code 2 after LEN_LO; no writes in either case.
- Stop bit forced 0 on the third payload byte -> frame_err with err_code 4 after 2 writes, then a following valid PARAM frame is received cleanly.
- Garbage bytes 00 FF 5A before SOF, plus a 1/4-bit low glitch on rx -> ignored; the subsequent valid TRACE frame of 1024 bytes gives frame_done.
- Timeout with the macro defined: rx held idle after LEN_LO -> err_code 5 exactly TIMEOUT_BITS×CLKS_PER_BIT cycles after the last byte_vld. rst asserted mid-payload -> all outputs 0 next cycle.
